// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of pipecpu.
//
// Holds the fetch PC, presents it as the IMEM address, and registers the
// fetched word into the IF/ID pipeline register. Hazard stalls, EX-stage
// branch redirects and the "B #0" halt idiom are handled here. After a halt
// word is seen, the stage drains for DRAIN cycles and then raises a sticky
// halted flag.
//
// Ports:
//   clk          in          single clock, rising edge
//   reset        in          synchronous, active-high
//   stall        in          hazard hold: freezes PC and IF/ID (RUN only)
//   br_taken     in          EX-stage branch taken this cycle
//   br_target    in  PC_W    redirect address while br_taken
//   imem_instr   in  32      combinational IMEM read data for pc_q
//   pc_q         out PC_W    current fetch PC / IMEM address
//   ifid_pc_q    out PC_W    PC of the instruction in IF/ID
//   ifid_instr_q out 32      instruction in IF/ID
//   ifid_valid_q out 1       IF/ID holds a real instruction (0 = bubble)
//   halt_seen    out 1       halt word fetched, drain in progress
//   halted       out 1       drain complete, sticky until reset
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int unsigned     DRAIN    = 8,
  parameter logic [31:0]     NOP_WORD = 32'hD503201F
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [31:0]     imem_instr,
  output logic [PC_W-1:0] pc_q,
  output logic [PC_W-1:0] ifid_pc_q,
  output logic [31:0]     ifid_instr_q,
  output logic            ifid_valid_q,
  output logic            halt_seen,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [7:0]      DRAIN_CNT = DRAIN[7:0];
  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(3'd4);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] ifid_pc_d;
  logic [31:0]     ifid_instr_d;
  logic            ifid_valid_d;
  logic            halt_word_s;

  // Recognise "B #0": unconditional branch opcode with a zero offset.
  always_comb begin
    halt_word_s = (imem_instr[31:26] == 6'h05) && (imem_instr[25:0] == 26'd0);
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      cnt_q        <= 8'd0;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= {PC_W{1'b0}};
      ifid_instr_q <= NOP_WORD;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Next-state and datapath selection in edge priority order.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    case (state_q)
      S_HALTED: begin
        // Frozen: branches and stalls are ignored until reset.
        state_d = S_HALTED;
      end
      S_DRAIN: begin
        if (br_taken) begin
          // A redirect cancels the speculative halt.
          state_d      = S_RUN;
          cnt_d        = 8'd0;
          pc_d         = br_target;
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end else begin
          // Stall does not pause the drain count.
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
          cnt_d        = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_RUN: begin
        if (br_taken) begin
          // Redirect wins over stall and masks halt detection this cycle.
          state_d      = S_RUN;
          cnt_d        = 8'd0;
          pc_d         = br_target;
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end else if (stall) begin
          state_d = S_RUN;
        end else if (halt_word_s) begin
          // The halt word itself never enters IF/ID.
          state_d      = S_DRAIN;
          cnt_d        = DRAIN_CNT;
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end else begin
          state_d      = S_RUN;
          pc_d         = pc_q + PC_STEP;
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_instr;
          ifid_valid_d = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: recover to RUN with a bubble.
        state_d      = S_RUN;
        cnt_d        = 8'd0;
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    if (state_q == S_DRAIN) begin
      halt_seen = 1'b1;
    end else begin
      halt_seen = 1'b0;
    end
    if (state_q == S_HALTED) begin
      halted = 1'b1;
    end else begin
      halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed bench for if_stage.
// dut0 uses default parameters; dut1 starts at 2^64-4 to cover PC wrap.
// Both fetch from one small word-addressed memory model (index = pc[7:2]).
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'hD503201F;
  localparam logic [31:0] HALT = 32'h14000000;
  localparam logic [63:0] RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset, rst1, stall, br_taken;
  logic [63:0] br_target;
  logic [31:0] mem [0:63];

  logic [31:0] imem0, imem1;
  logic [63:0] pc0, ifid_pc0, pc1, ifid_pc1;
  logic [31:0] instr0, instr1;
  logic        valid0, valid1, hs0, hs1, hd0, hd1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb imem0 = mem[pc0[7:2]];
  always_comb imem1 = mem[pc1[7:2]];

  if_stage dut0 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_instr(imem0), .pc_q(pc0),
    .ifid_pc_q(ifid_pc0), .ifid_instr_q(instr0), .ifid_valid_q(valid0),
    .halt_seen(hs0), .halted(hd0)
  );

  if_stage #(.RESET_PC(RPC1)) dut1 (
    .clk(clk), .reset(rst1), .stall(1'b0), .br_taken(1'b0),
    .br_target(64'd0), .imem_instr(imem1), .pc_q(pc1),
    .ifid_pc_q(ifid_pc1), .ifid_instr_q(instr1), .ifid_valid_q(valid1),
    .halt_seen(hs1), .halted(hd1)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset0(input string tag);
    check_eq({tag, " pc"},    pc0,      64'd0);
    check_eq({tag, " ifpc"},  ifid_pc0, 64'd0);
    check_eq({tag, " instr"}, {32'd0, instr0}, {32'd0, NOP});
    check_eq({tag, " valid"}, {63'd0, valid0}, 64'd0);
    check_eq({tag, " hs"},    {63'd0, hs0},    64'd0);
    check_eq({tag, " hd"},    {63'd0, hd0},    64'd0);
  endtask

  // Branch dut0 to 0x1C then fetch 0x1C so that pc0 sits on 0x20.
  task automatic goto_20();
    br_taken = 1'b1; br_target = 64'h1C;
    step();
    br_taken = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b1; rst1 = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 64'd0;
    step(); step();
    check_reset0("rst");

    // Sequential fetch
    reset = 1'b0;
    step();
    check_eq("seq1 pc", pc0, 64'd4);
    check_eq("seq1 ifpc", ifid_pc0, 64'd0);
    check_eq("seq1 instr", {32'd0, instr0}, 64'hA000_0000);
    check_eq("seq1 valid", {63'd0, valid0}, 64'd1);
    step();
    check_eq("seq2 pc", pc0, 64'd8);
    check_eq("seq2 ifpc", ifid_pc0, 64'd4);
    check_eq("seq2 instr", {32'd0, instr0}, 64'hA000_0001);

    // Stall hold for 3 cycles at PC=8
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall pc", pc0, 64'd8);
      check_eq("stall ifpc", ifid_pc0, 64'd4);
      check_eq("stall instr", {32'd0, instr0}, 64'hA000_0001);
      check_eq("stall valid", {63'd0, valid0}, 64'd1);
    end
    stall = 1'b0;
    step();
    check_eq("resume pc", pc0, 64'd12);
    check_eq("resume ifpc", ifid_pc0, 64'd8);
    check_eq("resume instr", {32'd0, instr0}, 64'hA000_0002);

    // Branch beats stall; halt word at PC=12 is ignored
    mem[3] = HALT;
    stall = 1'b1; br_taken = 1'b1; br_target = 64'h40;
    step();
    check_eq("brst pc", pc0, 64'h40);
    check_eq("brst valid", {63'd0, valid0}, 64'd0);
    check_eq("brst instr", {32'd0, instr0}, {32'd0, NOP});
    check_eq("brst ifpc", ifid_pc0, 64'd8);
    check_eq("brst hs", {63'd0, hs0}, 64'd0);
    stall = 1'b0; br_taken = 1'b0;
    mem[3] = 32'hA000_0003;

    // Halt and drain at 0x20
    mem[8] = HALT;
    goto_20();
    check_eq("pre pc", pc0, 64'h20);
    check_eq("pre ifpc", ifid_pc0, 64'h1C);
    check_eq("pre valid", {63'd0, valid0}, 64'd1);
    step();
    check_eq("halt hs", {63'd0, hs0}, 64'd1);
    check_eq("halt hd", {63'd0, hd0}, 64'd0);
    check_eq("halt pc", pc0, 64'h20);
    check_eq("halt valid", {63'd0, valid0}, 64'd0);
    check_eq("halt instr", {32'd0, instr0}, {32'd0, NOP});
    for (int k = 1; k < 8; k++) begin
      stall = (k == 2 || k == 3);
      step();
      check_eq("drain hs", {63'd0, hs0}, 64'd1);
      check_eq("drain hd", {63'd0, hd0}, 64'd0);
      check_eq("drain pc", pc0, 64'h20);
      check_eq("drain valid", {63'd0, valid0}, 64'd0);
    end
    stall = 1'b0;
    step();
    check_eq("done hd", {63'd0, hd0}, 64'd1);
    check_eq("done hs", {63'd0, hs0}, 64'd0);
    br_taken = 1'b1; br_target = 64'h100;
    step();
    br_taken = 1'b0;
    check_eq("sticky pc", pc0, 64'h20);
    check_eq("sticky hd", {63'd0, hd0}, 64'd1);
    step();
    check_eq("sticky2 hd", {63'd0, hd0}, 64'd1);

    // Speculative halt cancel
    reset = 1'b1;
    step();
    check_reset0("rsthalt");
    reset = 1'b0;
    goto_20();
    step(); step(); step();
    check_eq("spec hs", {63'd0, hs0}, 64'd1);
    br_taken = 1'b1; br_target = 64'h80;
    step();
    br_taken = 1'b0;
    check_eq("cancel hs", {63'd0, hs0}, 64'd0);
    check_eq("cancel pc", pc0, 64'h80);
    check_eq("cancel valid", {63'd0, valid0}, 64'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      check_eq("nohalt hd", {63'd0, hd0}, 64'd0);
      check_eq("nohalt hs", {63'd0, hs0}, 64'd0);
    end
    check_eq("after pc", pc0, 64'hB0);
    check_eq("after ifpc", ifid_pc0, 64'hAC);

    // Reset two cycles into drain
    goto_20();
    step();
    step();
    check_eq("mid hs", {63'd0, hs0}, 64'd1);
    reset = 1'b1;
    step();
    check_reset0("rstmid");
    reset = 1'b0;

    // PC wrap on dut1
    check_eq("wrap rst pc", pc1, RPC1);
    rst1 = 1'b0;
    step();
    check_eq("wrap pc", pc1, 64'd0);
    check_eq("wrap ifpc", ifid_pc1, RPC1);
    check_eq("wrap instr", {32'd0, instr1}, 64'hA000_003F);
    check_eq("wrap valid", {63'd0, valid1}, 64'd1);
    step();
    check_eq("wrap pc2", pc1, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
